// File: rtl/decode_pkg.sv
// Shared RV32I decode definitions: opcodes, one-hot type bit positions and the
// decoded bundle, sized for the widest supported XLEN and narrowed at the ports.
package decode_pkg;

    localparam int XLEN_MAX = 64;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam int TYPE_R = 0;
    localparam int TYPE_I = 1;
    localparam int TYPE_S = 2;
    localparam int TYPE_B = 3;
    localparam int TYPE_U = 4;
    localparam int TYPE_J = 5;

    typedef struct packed {
        logic [6:0]          opcode;
        logic [2:0]          funct3;
        logic [6:0]          funct7;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [4:0]          rd;
        logic [XLEN_MAX-1:0] imm;
        logic [5:0]          itype;
        logic                rs1_used;
        logic                rs2_used;
        logic                rd_wr;
        logic                illegal;
    } decoded_t;

    function automatic logic [XLEN_MAX-1:0] sext32(input logic [31:0] v);
        return {{(XLEN_MAX-32){v[31]}}, v};
    endfunction

endpackage

// File: rtl/rv_decode_comb.sv
// Combinational RV32I field decoder: raw instruction in, decoded bundle out.
module rv_decode_comb
    import decode_pkg::*;
#(
    parameter bit CHECK_ILLEGAL = 1'b1
) (
    input  logic [31:0] inst,
    output decoded_t    dec
);

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [XLEN_MAX-1:0] imm_i;
    logic [XLEN_MAX-1:0] imm_s;
    logic [XLEN_MAX-1:0] imm_b;
    logic [XLEN_MAX-1:0] imm_u;
    logic [XLEN_MAX-1:0] imm_j;
    logic rsvd;

    assign opc = inst[6:0];
    assign f3  = inst[14:12];
    assign f7  = inst[31:25];
    assign rs1 = inst[19:15];
    assign rs2 = inst[24:20];
    assign rd  = inst[11:7];

    assign imm_i = sext32({{20{inst[31]}}, inst[31:20]});
    assign imm_s = sext32({{20{inst[31]}}, inst[31:25], inst[11:7]});
    assign imm_b = sext32({{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0});
    assign imm_u = sext32({inst[31:12], 12'b0});
    assign imm_j = sext32({{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0});

    always_comb begin
        dec        = '0;
        rsvd       = 1'b0;
        dec.opcode = opc;
        case (opc)
            OPC_LOAD: begin
                dec.itype[TYPE_I] = 1'b1;
                dec.funct3        = f3;
                dec.rs1           = rs1;
                dec.rd            = rd;
                dec.imm           = imm_i;
                dec.rs1_used      = 1'b1;
                rsvd              = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
            end
            OPC_OP_IMM: begin
                dec.itype[TYPE_I] = 1'b1;
                dec.funct3        = f3;
                dec.rs1           = rs1;
                dec.rd            = rd;
                dec.imm           = imm_i;
                dec.rs1_used      = 1'b1;
                if (f3 == 3'd1 || f3 == 3'd5) dec.funct7 = f7;
                rsvd = ((f3 == 3'd1) && (f7 != 7'h00)) ||
                       ((f3 == 3'd5) && (f7 != 7'h00) && (f7 != 7'h20));
            end
            OPC_AUIPC, OPC_LUI: begin
                dec.itype[TYPE_U] = 1'b1;
                dec.rd            = rd;
                dec.imm           = imm_u;
            end
            OPC_STORE: begin
                dec.itype[TYPE_S] = 1'b1;
                dec.funct3        = f3;
                dec.rs1           = rs1;
                dec.rs2           = rs2;
                dec.imm           = imm_s;
                dec.rs1_used      = 1'b1;
                dec.rs2_used      = 1'b1;
                rsvd              = (f3 > 3'd2);
            end
            OPC_OP: begin
                dec.itype[TYPE_R] = 1'b1;
                dec.funct3        = f3;
                dec.funct7        = f7;
                dec.rs1           = rs1;
                dec.rs2           = rs2;
                dec.rd            = rd;
                dec.rs1_used      = 1'b1;
                dec.rs2_used      = 1'b1;
                rsvd = !((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5))));
            end
            OPC_BRANCH: begin
                dec.itype[TYPE_B] = 1'b1;
                dec.funct3        = f3;
                dec.rs1           = rs1;
                dec.rs2           = rs2;
                dec.imm           = imm_b;
                dec.rs1_used      = 1'b1;
                dec.rs2_used      = 1'b1;
                rsvd              = (f3 == 3'd2) || (f3 == 3'd3);
            end
            OPC_JALR: begin
                dec.itype[TYPE_I] = 1'b1;
                dec.funct3        = f3;
                dec.rs1           = rs1;
                dec.rd            = rd;
                dec.imm           = imm_i;
                dec.rs1_used      = 1'b1;
                rsvd              = (f3 != 3'd0);
            end
            OPC_JAL: begin
                dec.itype[TYPE_J] = 1'b1;
                dec.rd            = rd;
                dec.imm           = imm_j;
            end
            // FENCE/SYSTEM operand fields are not register accesses here
            OPC_MISC_MEM, OPC_SYSTEM: begin
                dec.itype[TYPE_I] = 1'b1;
                dec.funct3        = f3;
                dec.imm           = imm_i;
            end
            default: dec.illegal = 1'b1;
        endcase

        if (CHECK_ILLEGAL && rsvd) dec.illegal = 1'b1;
        dec.rd_wr = (dec.rd != 5'd0);

        if (dec.illegal) begin
            dec         = '0;
            dec.opcode  = opc;
            dec.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage with valid/ready on both sides; a skid register lets
// in_ready come straight from a flop while still sustaining one instruction per cycle.
//
//   state     | meaning
//   OCC_EMPTY | nothing held, out_valid=0
//   OCC_ONE   | output register holds the bundle on out_*
//   OCC_TWO   | output register stalled and skid register full, in_ready=0
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int TAG_W         = 4,
    parameter bit CHECK_ILLEGAL = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [6:0]       out_opcode,
    output logic [2:0]       out_funct3,
    output logic [6:0]       out_funct7,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [4:0]       out_rd,
    output logic [XLEN-1:0]  out_imm,
    output logic [5:0]       out_type,
    output logic             out_rs1_used,
    output logic             out_rs2_used,
    output logic             out_rd_wr,
    output logic             out_illegal,
    output logic [XLEN-1:0]  out_pc,
    output logic [TAG_W-1:0] out_tag
);

    // bit 0 = output register valid, bit 1 = skid register valid
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'b00,
        OCC_ONE   = 2'b01,
        OCC_TWO   = 2'b11
    } occ_t;

    typedef struct packed {
        decoded_t         dec;
        logic [XLEN-1:0]  pc;
        logic [TAG_W-1:0] tag;
    } entry_t;

    occ_t     occ_q;
    entry_t   or_q;
    entry_t   sr_q;
    entry_t   in_entry;
    decoded_t dec;
    logic     unused_imm_hi;

    rv_decode_comb #(.CHECK_ILLEGAL(CHECK_ILLEGAL)) u_dec (
        .inst (in_inst),
        .dec  (dec)
    );

    assign in_entry = '{dec: dec, pc: in_pc, tag: in_tag};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= OCC_EMPTY;
            or_q  <= '0;
            sr_q  <= '0;
        end else if (flush) begin
            occ_q <= OCC_EMPTY;
        end else begin
            case (occ_q)
                OCC_EMPTY: begin
                    if (in_valid) begin
                        or_q  <= in_entry;
                        occ_q <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (in_valid && !out_ready) begin
                        sr_q  <= in_entry;
                        occ_q <= OCC_TWO;
                    end else if (in_valid) begin
                        or_q  <= in_entry;
                    end else if (out_ready) begin
                        occ_q <= OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    if (out_ready) begin
                        or_q  <= sr_q;
                        occ_q <= OCC_ONE;
                    end
                end
                default: occ_q <= OCC_EMPTY;
            endcase
        end
    end

    assign in_ready  = ~occ_q[1];
    assign out_valid = occ_q[0];

    assign out_opcode   = or_q.dec.opcode;
    assign out_funct3   = or_q.dec.funct3;
    assign out_funct7   = or_q.dec.funct7;
    assign out_rs1      = or_q.dec.rs1;
    assign out_rs2      = or_q.dec.rs2;
    assign out_rd       = or_q.dec.rd;
    assign out_imm      = or_q.dec.imm[XLEN-1:0];
    assign out_type     = or_q.dec.itype;
    assign out_rs1_used = or_q.dec.rs1_used;
    assign out_rs2_used = or_q.dec.rs2_used;
    assign out_rd_wr    = or_q.dec.rd_wr;
    assign out_illegal  = or_q.dec.illegal;
    assign out_pc       = or_q.pc;
    assign out_tag      = or_q.tag;

    assign unused_imm_hi = ^or_q.dec.imm;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: random traffic against a spec-level decode
// model, plus directed cases for latency, stalls, flush, reset and illegal encodings.
module tb_decode_stage;

    typedef struct packed {
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [5:0]  typ;
        logic        u1;
        logic        u2;
        logic        wr;
        logic        ill;
        logic [31:0] pc;
        logic [3:0]  tag;
    } exp_t;

    localparam logic [5:0] T_R = 6'b000001, T_I = 6'b000010, T_S = 6'b000100,
                           T_B = 6'b001000, T_U = 6'b010000, T_J = 6'b100000;
    localparam logic [6:0] OPCS [11] = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33,
                                         7'h37, 7'h63, 7'h67, 7'h6F, 7'h73};

    logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] in_inst = '0, in_pc = '0;
    logic [3:0]  in_tag = '0;
    logic in_ready, out_valid, out_rs1_used, out_rs2_used, out_rd_wr, out_illegal;
    logic [6:0] out_opcode, out_funct7;
    logic [2:0] out_funct3;
    logic [4:0] out_rs1, out_rs2, out_rd;
    logic [31:0] out_imm, out_pc;
    logic [5:0] out_type;
    logic [3:0] out_tag;

    // lax-check instance (CHECK_ILLEGAL=0)
    logic a_valid = 1'b0;
    logic [31:0] a_inst = '0;
    logic a_in_ready, a_out_valid, a_u1, a_u2, a_wr, a_ill;
    logic [6:0] a_opc, a_f7;
    logic [2:0] a_f3;
    logic [4:0] a_rs1, a_rs2, a_rd;
    logic [31:0] a_imm, a_pc;
    logic [5:0] a_type;
    logic [3:0] a_tag;

    // XLEN=64 instance
    logic w_valid = 1'b0;
    logic [31:0] w_inst = '0;
    logic w_in_ready, w_out_valid, w_u1, w_u2, w_wr, w_ill;
    logic [6:0] w_opc, w_f7;
    logic [2:0] w_f3;
    logic [4:0] w_rs1, w_rs2, w_rd;
    logic [63:0] w_imm, w_pc;
    logic [5:0] w_type;
    logic [3:0] w_tag;

    int n_cmp = 0;
    int n_bad = 0;
    exp_t sb[$];
    exp_t mon_exp, mon_act;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .TAG_W(4), .CHECK_ILLEGAL(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .in_tag(in_tag), .out_valid(out_valid),
        .out_ready(out_ready), .out_opcode(out_opcode), .out_funct3(out_funct3),
        .out_funct7(out_funct7), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_imm(out_imm), .out_type(out_type), .out_rs1_used(out_rs1_used),
        .out_rs2_used(out_rs2_used), .out_rd_wr(out_rd_wr), .out_illegal(out_illegal),
        .out_pc(out_pc), .out_tag(out_tag));

    decode_stage #(.XLEN(32), .TAG_W(4), .CHECK_ILLEGAL(1'b0)) dut_lax (
        .clk(clk), .rst_n(rst_n), .flush(1'b0), .in_valid(a_valid), .in_ready(a_in_ready),
        .in_inst(a_inst), .in_pc(32'h0), .in_tag(4'h0), .out_valid(a_out_valid),
        .out_ready(1'b1), .out_opcode(a_opc), .out_funct3(a_f3), .out_funct7(a_f7),
        .out_rs1(a_rs1), .out_rs2(a_rs2), .out_rd(a_rd), .out_imm(a_imm), .out_type(a_type),
        .out_rs1_used(a_u1), .out_rs2_used(a_u2), .out_rd_wr(a_wr), .out_illegal(a_ill),
        .out_pc(a_pc), .out_tag(a_tag));

    decode_stage #(.XLEN(64), .TAG_W(4), .CHECK_ILLEGAL(1'b1)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(1'b0), .in_valid(w_valid), .in_ready(w_in_ready),
        .in_inst(w_inst), .in_pc(64'h0), .in_tag(4'h0), .out_valid(w_out_valid),
        .out_ready(1'b1), .out_opcode(w_opc), .out_funct3(w_f3), .out_funct7(w_f7),
        .out_rs1(w_rs1), .out_rs2(w_rs2), .out_rd(w_rd), .out_imm(w_imm), .out_type(w_type),
        .out_rs1_used(w_u1), .out_rs2_used(w_u2), .out_rd_wr(w_wr), .out_illegal(w_ill),
        .out_pc(w_pc), .out_tag(w_tag));

    // Reference decode built from the format rules with plain arithmetic.
    function automatic exp_t model(logic [31:0] i, logic [31:0] pc, logic [3:0] tag, bit chk);
        exp_t e;
        logic [31:0] s, imm_i, imm_s, imm_b, imm_u, imm_j, imm;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [5:0] t;
        bit known, ok, r1, r2, wd, f7v;
        f3 = i[14:12];
        f7 = i[31:25];
        s     = $signed(i) >>> 20;
        imm_i = s;
        imm_s = (s & ~32'h1F) | 32'(i[11:7]);
        imm_b = (32'($signed(i) >>> 31) << 12) | (32'(i[7]) << 11) |
                (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
        imm_u = i & 32'hFFFFF000;
        imm_j = (32'($signed(i) >>> 31) << 20) | (32'(i[19:12]) << 12) |
                (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
        known = 1; ok = 1; r1 = 0; r2 = 0; wd = 0; f7v = 0; t = '0; imm = '0;
        case (i[6:0])
            7'h03: begin t = T_I; imm = imm_i; r1 = 1; wd = 1; ok = !(f3 inside {3'd3, 3'd6, 3'd7}); end
            7'h13: begin
                t = T_I; imm = imm_i; r1 = 1; wd = 1;
                f7v = (f3 == 3'd1) || (f3 == 3'd5);
                if (f3 == 3'd1) ok = (f7 == 7'h00);
                if (f3 == 3'd5) ok = (f7 == 7'h00) || (f7 == 7'h20);
            end
            7'h17, 7'h37: begin t = T_U; imm = imm_u; wd = 1; end
            7'h23: begin t = T_S; imm = imm_s; r1 = 1; r2 = 1; ok = (f3 <= 3'd2); end
            7'h33: begin
                t = T_R; r1 = 1; r2 = 1; wd = 1; f7v = 1;
                ok = (f7 == 7'h00) || ((f7 == 7'h20) && (f3 == 3'd0 || f3 == 3'd5));
            end
            7'h63: begin t = T_B; imm = imm_b; r1 = 1; r2 = 1; ok = !(f3 inside {3'd2, 3'd3}); end
            7'h67: begin t = T_I; imm = imm_i; r1 = 1; wd = 1; ok = (f3 == 3'd0); end
            7'h6F: begin t = T_J; imm = imm_j; wd = 1; end
            7'h0F, 7'h73: begin t = T_I; imm = imm_i; end
            default: known = 0;
        endcase
        e = '0;
        e.opc = i[6:0];
        e.pc  = pc;
        e.tag = tag;
        if (!known || (chk && !ok)) begin
            e.ill = 1'b1;
        end else begin
            e.typ = t;
            e.imm = imm;
            e.f3  = (t == T_U || t == T_J) ? 3'd0 : f3;
            e.f7  = f7v ? f7 : 7'd0;
            e.rs1 = r1 ? i[19:15] : 5'd0;
            e.rs2 = r2 ? i[24:20] : 5'd0;
            e.rd  = wd ? i[11:7] : 5'd0;
            e.u1  = r1;
            e.u2  = r2;
            e.wr  = wd && (i[11:7] != 5'd0);
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] i;
        i = $urandom;
        if ($urandom_range(0, 9) != 0) i[6:0] = OPCS[$urandom_range(0, 10)];
        if ($urandom_range(0, 1) != 0) i[31:25] = ($urandom_range(0, 1) != 0) ? 7'h00 : 7'h20;
        return i;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic drive(input logic [31:0] inst, input logic [31:0] pc);
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
        in_tag   = pc[5:2];
    endtask

    // Monitor: samples mid-cycle, pushes accepted inputs and checks drained outputs.
    always @(negedge clk) begin
        if (rst_n) begin
            if (flush) begin
                sb.delete();
            end else begin
                if (out_valid && out_ready) begin
                    mon_act = {out_opcode, out_funct3, out_funct7, out_rs1, out_rs2, out_rd,
                               out_imm, out_type, out_rs1_used, out_rs2_used, out_rd_wr,
                               out_illegal, out_pc, out_tag};
                    n_cmp++;
                    if (sb.size() == 0) begin
                        n_bad++;
                        $display("FAIL sb_unexpected_output: got %h expected none", mon_act);
                    end else begin
                        mon_exp = sb.pop_front();
                        if (mon_act !== mon_exp) begin
                            n_bad++;
                            $display("FAIL bundle pc=%h: got %h expected %h", mon_exp.pc, mon_act, mon_exp);
                        end
                    end
                end
                if (in_valid && in_ready) sb.push_back(model(in_inst, in_pc, in_tag, 1'b1));
            end
        end
    end

    initial begin
        repeat (2) step();
        at_neg();
        check("rst_out_valid", out_valid, 0);
        check("rst_imm", out_imm, 0);
        check("rst_type", out_type, 0);
        check("rst_pc", out_pc, 0);
        rst_n = 1'b1;
        step();
        at_neg();
        check("post_rst_in_ready", in_ready, 1);

        step();
        out_ready = 1'b1;
        drive(32'hFFF10093, 32'h100);
        step();
        in_valid = 1'b0;
        at_neg();
        check("addi_valid", out_valid, 1);
        check("addi_rd", out_rd, 1);
        check("addi_rs1", out_rs1, 2);
        check("addi_rs2", out_rs2, 0);
        check("addi_imm", out_imm, 32'hFFFFFFFF);
        check("addi_type", out_type, T_I);
        check("addi_rd_wr", out_rd_wr, 1);
        check("addi_pc", out_pc, 32'h100);

        step();
        drive(32'hFE208EE3, 32'h104);
        step();
        drive(32'h123452B7, 32'h108);
        at_neg();
        check("beq_imm", out_imm, 32'hFFFFFFFC);
        check("beq_rs1", out_rs1, 1);
        check("beq_rs2", out_rs2, 2);
        check("beq_rd", out_rd, 0);
        check("beq_type", out_type, T_B);
        check("b2b_in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        at_neg();
        check("lui_valid", out_valid, 1);
        check("lui_imm", out_imm, 32'h12345000);
        check("lui_rd", out_rd, 5);
        check("lui_funct3", out_funct3, 0);
        check("lui_type", out_type, T_U);

        step();
        out_ready = 1'b0;
        drive(32'h00100093, 32'h200);
        step();
        drive(32'h00200113, 32'h204);
        step();
        drive(32'h00300193, 32'h208);
        at_neg();
        check("stall_in_ready", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
        step();
        at_neg();
        check("stall_hold_in_ready", in_ready, 0);
        check("stall_hold_pc", out_pc, 32'h200);
        out_ready = 1'b1;
        at_neg();
        check("sr_drain_in_ready", in_ready, 1);
        check("sr_drain_pc", out_pc, 32'h204);
        step();
        in_valid = 1'b0;
        at_neg();
        check("third_pc", out_pc, 32'h208);

        step();
        drive(32'h00000000, 32'h300);
        a_valid = 1'b1;
        a_inst  = 32'h40001033;
        step();
        drive(32'h40001033, 32'h304);
        a_valid = 1'b0;
        at_neg();
        check("zero_illegal", out_illegal, 1);
        check("zero_type", out_type, 0);
        check("zero_imm", out_imm, 0);
        check("lax_illegal", a_ill, 0);
        check("lax_type", a_type, T_R);
        check("lax_funct7", a_f7, 7'h20);
        step();
        in_valid = 1'b0;
        at_neg();
        check("sll20_illegal", out_illegal, 1);
        check("sll20_type", out_type, 0);
        check("sll20_imm", out_imm, 0);

        step();
        out_ready = 1'b0;
        drive(32'h00400213, 32'h400);
        step();
        drive(32'h00500293, 32'h404);
        step();
        drive(32'h00600313, 32'h408);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        at_neg();
        check("flush_out_valid", out_valid, 0);
        check("flush_in_ready", in_ready, 1);
        step();
        out_ready = 1'b1;
        drive(32'h00700393, 32'h40C);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        at_neg();
        check("flush_drop_empty", out_valid, 0);
        repeat (3) step();
        at_neg();
        check("flush_nothing_emerges", out_valid, 0);

        step();
        out_ready = 1'b0;
        drive(32'hFFF10093, 32'h500);
        step();
        drive(32'h00100093, 32'h504);
        step();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_imm", out_imm, 0);
        check("arst_rd", out_rd, 0);
        check("arst_pc", out_pc, 0);
        check("arst_in_ready", in_ready, 1);
        at_neg();
        #2;
        rst_n = 1'b1;
        step();
        at_neg();
        check("arst_release_in_ready", in_ready, 1);
        check("arst_release_out_valid", out_valid, 0);

        step();
        w_valid = 1'b1;
        w_inst  = 32'hFFF10093;
        step();
        w_valid = 1'b0;
        at_neg();
        check("x64_valid", w_out_valid, 1);
        check("x64_imm", w_imm, 64'hFFFFFFFFFFFFFFFF);

        for (int c = 0; c < 3000; c++) begin
            step();
            in_valid  = ($urandom_range(0, 3) != 0);
            in_inst   = rand_inst();
            in_pc     = $urandom & 32'hFFFFFFFC;
            in_tag    = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 99) == 0);
        end
        step();
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();
        at_neg();
        check("drain_sb_empty", sb.size(), 0);
        check("drain_out_valid", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Parametrised, pipelined successor to the combinational/negedge RV32I field decoder.
- Sits between fetch and execute as a registered pipeline stage with valid/ready handshakes on both sides, using a 2-entry skid buffer for full throughput.
- Decodes the full RV32I base opcode set, including FENCE and SYSTEM, into a single registered bundle.
- The bundle carries register fields, an XLEN-wide sign-extended immediate, a one-hot instruction type, register-use flags and an illegal-instruction flag, with PC and a tag carried alongside.

Parameters:
- XLEN, 32: width of imm and pc; legal values 32 or 64. Immediates are sign-extended to XLEN; U-type is {inst[31:12],12'b0} sign-extended.
- TAG_W, 4: width of the sideband tag carried alongside each instruction.
- CHECK_ILLEGAL, 1: when 1, reserved funct3/funct7 encodings set illegal; when 0, only an unknown opcode sets illegal.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; discards all held instructions.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept an instruction.
- in_inst  in  32  raw instruction.
- in_pc  in  XLEN  instruction PC.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  downstream accepts the bundle.
- out_opcode  out  7  inst[6:0].
- out_funct3  out  3  0 for U/J types.
- out_funct7  out  7  non-zero only for R-type and shift-immediates (inst[31:25]).
- out_rs1, out_rs2, out_rd  out  5 each  zeroed when the field is unused.
- out_imm  out  XLEN  decoded immediate; 0 for R-type.
- out_type  out  6  one-hot {J,U,B,S,I,R}; all-zero if illegal.
- out_rs1_used, out_rs2_used, out_rd_wr  out  1 each  register usage flags; out_rd_wr=0 when rd==0.
- out_illegal  out  1  illegal/unsupported encoding.
- out_pc  out  XLEN  carried PC.
- out_tag  out  TAG_W  carried tag.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - out_valid=0 and skid_valid=0.
  - All bundle outputs are 0.
  - in_ready=1 one cycle after rst_n deasserts, and stays 1 while no entry is held.
  - Reset mid-operation drops both entries with no partial output.
- Transfer rule: a transfer occurs on a rising edge when valid&&ready on that side.
- in_ready = ~skid_valid. This is registered-derived; there is no combinational path from out_ready.
- Latency: 1 cycle. An instruction accepted at edge N appears on out_* after edge N, when the output register was empty or drained at N.
- Storage: two entries, the output register (OR) and the skid register (SR).
  - Accept while OR is empty or OR drains this edge: the decode goes to OR, or SR content moves to OR first if SR is valid.
  - Accept while OR is held (out_valid && !out_ready): the decode goes to SR.
  - SR valid && OR drains: SR moves to OR and SR empties. A simultaneous accept is impossible because in_ready=0.
- State machine (occupancy):
  - EMPTY -> ONE on accept.
  - ONE -> TWO on accept with a stall.
  - ONE -> EMPTY on drain without accept.
  - TWO -> ONE on drain.
  - All states -> EMPTY on flush.
- Order: strictly FIFO; no reordering or duplication.
- flush:
  - Clears OR and SR at the edge.
  - out_valid=0 the next cycle.
  - An input presented in the same cycle as flush is dropped, even though in_ready=1.
  - Flush has priority over accept and drain.
- Decode is computed combinationally from in_inst before the register; imm bit placement follows RV32I I/S/B/U/J formats.
- Illegal conditions:
  - Opcode not in {LOAD, OP-IMM, AUIPC, STORE, OP, LUI, BRANCH, JALR, JAL, MISC-MEM, SYSTEM}.
  - inst[1:0]!=2'b11.
  - When CHECK_ILLEGAL=1, also:
    - LOAD f3 in {3,6,7};
    - STORE f3>2;
    - BRANCH f3 in {2,3};
    - JALR f3!=0;
    - OP with funct7 not 0x00, or 0x20 other than with f3 in {0,5};
    - SLLI with f7!=0;
    - SRLI/SRAI with f7 not in {0x00,0x20}.
- When illegal: register fields, use flags and imm are 0. Opcode, pc and tag are still carried.
- FENCE/SYSTEM: type I. Flags are rs1_used=0, rs2_used=0, rd_wr=0. imm = inst[31:20] sign-extended.

Decomposition:
- Package decode_pkg holds:
  - opcode localparams (OPC_LOAD ... OPC_SYSTEM);
  - the type one-hot bit index constants;
  - a packed struct decoded_t {opcode, funct3, funct7, rs1, rs2, rd, imm, type, use flags, illegal}, parameterised via XLEN max 64 and truncated at the port.
- Sub-module rv_decode_comb: purely combinational, in_inst -> decoded_t, parameter CHECK_ILLEGAL.
- decode_stage wraps rv_decode_comb with the skid/output registers.

Test Plan:
- addi x1,x2,-1 (0xFFF10093), pc=0x100, out_ready=1 -> next cycle out_valid=1, rd=1, rs1=2, rs2=0, imm=0xFFFFFFFF, type=I, rd_wr=1, pc=0x100.
- beq x1,x2,-4 (0xFE208EE3) then lui x5,0x12345 (0x123452B7) back-to-back -> first imm=0xFFFFFFFC, rs1=1, rs2=2, rd=0, type=B; second imm=0x12345000, rd=5, funct3=0, type=U. Throughput 1 per cycle.
- out_ready=0 with 3 consecutive valid inputs -> 2 accepted, in_ready=0 on the 3rd. Release out_ready -> outputs in order, and the 3rd is accepted the cycle after SR drains.
- 0x00000000, then 0x40001033 (sll with f7=0x20) with CHECK_ILLEGAL=1 -> both illegal=1, type=0, imm=0. With CHECK_ILLEGAL=0 the second decodes as R-type with illegal=0.
- TWO-occupancy stall plus flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushed-cycle input never emerges.
- rst_n pulsed low mid-stall (asynchronously, off-edge) -> out_valid=0 immediately, all outputs 0, in_ready=1 after release; XLEN=64 run of addi gives imm=0xFFFFFFFFFFFFFFFF.
